// File: rtl/sl_pkg.sv
// sl_pkg
//   Shared definitions for the SL line blocks (transmitter, receiver, bridge):
//   FSM state encoding, config word field positions, word-length decode and
//   status word bit indices.
package sl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PULSE = 3'd1,
        GAP   = 3'd2,
        STOP  = 3'd3,
        IFG   = 3'd4
    } sl_state_e;

    // config word fields
    localparam int CFG_LEN_LSB = 0;
    localparam int CFG_LEN_MSB = 1;
    localparam int CFG_PAR_EN  = 2;
    localparam int CFG_PAR_ODD = 3;
    localparam int CFG_SPD_LSB = 4;
    localparam int CFG_SPD_MSB = 7;

    // word length: code 0..3 selects 8/16/24/32 bits
    localparam int unsigned LEN_UNIT = 8;

    // status word bits
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_OVERRUN = 2;

    function automatic int unsigned word_len(input logic [1:0] code);
        return (32'(code) + 32'd1) * LEN_UNIT;
    endfunction

endpackage

// File: rtl/sl_bit_timer.sv
// sl_bit_timer
//   Loadable down-counter used to time half-bit (H) and double half-bit (2H)
//   intervals on the SL line. Loading N-1 makes tc rise after N clocks.
//   Ports:
//     clk, reset_n  clock and asynchronous active-low reset
//     load          load load_val into the counter this edge
//     load_val      interval length minus one
//     tc            terminal count (counter at zero)
module sl_bit_timer #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] load_val,
    output logic                 tc
);

    logic [DIV_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DIV_WIDTH'(1);
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/sl_transmitter.sv
// sl_transmitter
//   Serialises one data word onto the SL line pair with return-to-idle pulse
//   coding, LSB first, optional parity bit and a both-low stop marker,
//   followed by an inter-frame gap.
//   Ports:
//     clk, reset_n   clock and asynchronous active-low reset
//     data_i         word to send (sampled only on an accepted send_i)
//     config_i       {speed[7:4], par_odd, par_en, len[1:0]} (sampled on send_i)
//     send_i         single-cycle start strobe
//     sl0, sl1       zero-line / one-line, idle high, active-low pulses
//     busy_o         transmission in progress
//     status_o       {.., overrun, done, busy}
//
//   state | meaning
//   IDLE  | both lines high, waiting for send_i
//   PULSE | current bit pulse low on sl1 ('1') or sl0 ('0') for H clocks
//   GAP   | both lines high for H clocks between bits
//   STOP  | both lines low for H clocks
//   IFG   | both lines high for 2H clocks, then done
module sl_transmitter
    import sl_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int CONFIG_REG_WIDTH = 8,
    parameter int STATUS_REG_WIDTH = 8,
    parameter int CLK_DIV          = 4,
    parameter int DIV_WIDTH        = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [DATA_WIDTH-1:0]       data_i,
    input  logic [CONFIG_REG_WIDTH-1:0] config_i,
    input  logic                        send_i,
    output logic                        sl0,
    output logic                        sl1,
    output logic                        busy_o,
    output logic [STATUS_REG_WIDTH-1:0] status_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 2);

    sl_state_e            state_q, state_d;
    logic [DATA_WIDTH:0]  shift_q;      // data bits with parity in the slot after the last one
    logic [CNT_W-1:0]     bits_left_q;
    logic [3:0]           spd_q;
    logic                 sl0_q, sl1_q, busy_q, done_q, ovr_q;

    logic                 capture, advance, done_set, tmr_load, tmr_tc, cur_bit;
    logic                 sl0_d, sl1_d;

    // frame assembly from the live inputs, used only on the capture edge
    int unsigned          len_new;
    logic [DATA_WIDTH-1:0] masked;
    logic                 par_new;
    logic [DATA_WIDTH:0]  frame_new;
    logic [CNT_W-1:0]     n_new;

    always_comb begin
        len_new = word_len(config_i[CFG_LEN_MSB:CFG_LEN_LSB]);
        masked  = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            masked[i] = data_i[i] & (32'(i) < len_new);
        end
        par_new   = (^masked) ^ config_i[CFG_PAR_ODD];
        frame_new = {1'b0, masked};
        if (config_i[CFG_PAR_EN]) begin
            frame_new = frame_new | ((DATA_WIDTH+1)'(par_new) << len_new);
        end
        n_new = CNT_W'(len_new) + CNT_W'(config_i[CFG_PAR_EN]);
    end

    // interval length: the new speed on the start edge, the latched one after
    logic [3:0]           spd_sel;
    logic [DIV_WIDTH-1:0] half_len, load_val;

    assign spd_sel  = (state_q == IDLE) ? config_i[CFG_SPD_MSB:CFG_SPD_LSB] : spd_q;
    assign half_len = DIV_WIDTH'((32'(spd_sel) + 32'd1) * 32'(CLK_DIV));
    assign load_val = (state_d == IFG) ? ((half_len << 1) - DIV_WIDTH'(1))
                                       : (half_len - DIV_WIDTH'(1));

    sl_bit_timer #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (load_val),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        capture  = 1'b0;
        advance  = 1'b0;
        done_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (send_i) begin
                    state_d  = PULSE;
                    tmr_load = 1'b1;
                    capture  = 1'b1;
                end
            end
            PULSE: begin
                if (tmr_tc) begin
                    state_d  = GAP;
                    tmr_load = 1'b1;
                    advance  = 1'b1;
                end
            end
            GAP: begin
                if (tmr_tc) begin
                    state_d  = (bits_left_q != '0) ? PULSE : STOP;
                    tmr_load = 1'b1;
                end
            end
            STOP: begin
                if (tmr_tc) begin
                    state_d  = IFG;
                    tmr_load = 1'b1;
                end
            end
            IFG: begin
                if (tmr_tc) begin
                    state_d  = IDLE;
                    done_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // the shifter advances on PULSE exit, so shift_q[0] is always the
        // bit of the next pulse; on the start edge it is still data_i[0]
        cur_bit = capture ? data_i[0] : shift_q[0];
        sl0_d   = !(((state_d == PULSE) && !cur_bit) || (state_d == STOP));
        sl1_d   = !(((state_d == PULSE) &&  cur_bit) || (state_d == STOP));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bits_left_q <= '0;
            spd_q       <= '0;
            sl0_q       <= 1'b1;
            sl1_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            sl0_q   <= sl0_d;
            sl1_q   <= sl1_d;
            busy_q  <= (state_d != IDLE);
            if (capture) begin
                shift_q     <= frame_new;
                bits_left_q <= n_new;
                spd_q       <= config_i[CFG_SPD_MSB:CFG_SPD_LSB];
                done_q      <= 1'b0;
                ovr_q       <= 1'b0;
            end else begin
                if (advance) begin
                    shift_q     <= shift_q >> 1;
                    bits_left_q <= bits_left_q - CNT_W'(1);
                end
                if (done_set) begin
                    done_q <= 1'b1;
                end
                // includes a strobe coinciding with IFG exit
                if (send_i && (state_q != IDLE)) begin
                    ovr_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        status_o               = '0;
        status_o[STAT_BUSY]    = busy_q;
        status_o[STAT_DONE]    = done_q;
        status_o[STAT_OVERRUN] = ovr_q;
    end

    assign sl0    = sl0_q;
    assign sl1    = sl1_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_sl_transmitter.sv
// tb_sl_transmitter
//   Self-checking bench for sl_transmitter (CLK_DIV=2). A reference model
//   builds the expected per-clock {sl1,sl0} waveform of a frame straight
//   from the line coding rules; table vectors, random frames and a few
//   hand-written sequences (overrun, strobe on IFG exit, reset mid-word)
//   are compared against it.
module tb_sl_transmitter;

    localparam int CLK_DIV = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] data_i;
    logic [7:0]  config_i;
    logic        send_i;
    logic        sl0, sl1, busy_o;
    logic [7:0]  status_o;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [1:0] exp_q[$];    // expected {sl1,sl0} per clock while busy

    sl_transmitter #(
        .DATA_WIDTH       (32),
        .CONFIG_REG_WIDTH (8),
        .STATUS_REG_WIDTH (8),
        .CLK_DIV          (CLK_DIV),
        .DIV_WIDTH        (8)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .data_i   (data_i),
        .config_i (config_i),
        .send_i   (send_i),
        .sl0      (sl0),
        .sl1      (sl1),
        .busy_o   (busy_o),
        .status_o (status_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_bit(input logic b, input int h);
        repeat (h) exp_q.push_back(b ? 2'b01 : 2'b10);
        repeat (h) exp_q.push_back(2'b11);
    endtask

    task automatic build_model(input logic [31:0] d, input logic [7:0] c);
        int len, h, ones;
        exp_q.delete();
        len  = (int'(c[1:0]) + 1) * 8;
        h    = (int'(c[7:4]) + 1) * CLK_DIV;
        ones = 0;
        for (int i = 0; i < len; i++) begin
            push_bit(d[i], h);
            ones += int'(d[i]);
        end
        if (c[2]) push_bit(c[3] ? (ones % 2 == 0) : (ones % 2 == 1), h);
        repeat (h) exp_q.push_back(2'b00);
        repeat (2 * h) exp_q.push_back(2'b11);
    endtask

    // Sends one frame and compares every clock of it against the model.
    // ovr_at >= 0 pulses send_i (with different data/config) after that sample.
    task automatic run_frame(input logic [31:0] d, input logic [7:0] c, input int exp_busy,
                             input logic [7:0] exp_stat, input int ovr_at, input string nm);
        int busy_cnt;
        build_model(d, c);
        @(negedge clk);
        data_i   = d;
        config_i = c;
        send_i   = 1'b1;
        @(negedge clk);
        send_i   = 1'b0;
        busy_cnt = 0;
        chk({nm, " status at start"}, 32'(status_o), 32'h01);
        for (int k = 0; k < exp_q.size(); k++) begin
            chk($sformatf("%s line[%0d]", nm, k), 32'({sl1, sl0}), 32'(exp_q[k]));
            if (busy_o) busy_cnt++;
            if (ovr_at >= 0 && k == ovr_at + 2)
                chk({nm, " status overrun busy"}, 32'(status_o), 32'h05);
            send_i = 1'b0;
            if (k == ovr_at) begin
                send_i   = 1'b1;
                data_i   = ~d;
                config_i = ~c;
            end
            @(negedge clk);
        end
        send_i = 1'b0;
        chk({nm, " busy after"}, 32'(busy_o), 32'h0);
        chk({nm, " busy cycles"}, 32'(busy_cnt), 32'(exp_busy));
        chk({nm, " status after"}, 32'(status_o), 32'(exp_stat));
    endtask

    task automatic idle_check(input int cycles, input string nm);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            chk($sformatf("%s lines[%0d]", nm, k), 32'({sl1, sl0, busy_o}), 32'b110);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [7:0]  cfg;
        int          busy;
        logic [7:0]  stat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{data: 32'h000000A5, cfg: 8'h00, busy: 38,  stat: 8'h02};
        vecs[1] = '{data: 32'h00000003, cfg: 8'h0C, busy: 42,  stat: 8'h02};
        vecs[2] = '{data: 32'h00000003, cfg: 8'h04, busy: 42,  stat: 8'h02};
        vecs[3] = '{data: 32'hFFFF0000, cfg: 8'h13, busy: 268, stat: 8'h02};
        vecs[4] = '{data: 32'hDEAD1234, cfg: 8'h01, busy: 70,  stat: 8'h02};
        vecs[5] = '{data: 32'h00C35A5A, cfg: 8'h2E, busy: 318, stat: 8'h02};

        reset_n  = 1'b0;
        data_i   = '0;
        config_i = '0;
        send_i   = 1'b0;

        // reset and idle
        repeat (3) @(negedge clk);
        chk("reset lines", 32'({sl1, sl0}), 32'b11);
        chk("reset busy", 32'(busy_o), 32'h0);
        chk("reset status", 32'(status_o), 32'h00);
        reset_n = 1'b1;
        idle_check(10, "idle after reset");
        chk("idle status", 32'(status_o), 32'h00);

        // table vectors
        for (int v = 0; v < 6; v++)
            run_frame(vecs[v].data, vecs[v].cfg, vecs[v].busy, vecs[v].stat, -1,
                      $sformatf("vec%0d", v));

        // overrun 5 clocks into a frame; the next send clears the status
        run_frame(32'h000000A5, 8'h00, 38, 8'h06, 5, "overrun");
        run_frame(32'h0000005C, 8'h04, 42, 8'h02, -1, "after overrun");

        // strobe on the IFG exit edge is ignored and flags overrun
        run_frame(32'h0000003C, 8'h00, 38, 8'h06, 37, "ifg exit");
        idle_check(6, "ifg exit ignored");

        // reset during bit 3 (A5 bit 3 is '0', so sl0 is low)
        @(negedge clk);
        data_i   = 32'h000000A5;
        config_i = 8'h00;
        send_i   = 1'b1;
        @(negedge clk);
        send_i   = 1'b0;
        repeat (13) @(negedge clk);
        chk("midword bit3 line", 32'({sl1, sl0}), 32'b10);
        #2 reset_n = 1'b0;
        #1;
        chk("midword reset lines", 32'({sl1, sl0}), 32'b11);
        chk("midword reset busy", 32'(busy_o), 32'h0);
        chk("midword reset status", 32'(status_o), 32'h00);
        @(negedge clk);
        reset_n = 1'b1;
        idle_check(3, "after midword reset");
        run_frame(32'h0000005C, 8'h04, 42, 8'h02, -1, "fresh after reset");

        // random frames, speed kept low to bound run time
        for (int r = 0; r < 8; r++) begin
            logic [31:0] d;
            logic [7:0]  c;
            int          n, h;
            d = $urandom;
            c = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            n = (int'(c[1:0]) + 1) * 8 + int'(c[2]);
            h = (int'(c[7:4]) + 1) * CLK_DIV;
            run_frame(d, c, n * 2 * h + 3 * h, 8'h02, -1, $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
